// File: rtl/bm_dag1_log_drv.sv
// ---------------------------------------------------------------------------------------------
// bm_dag1_log_drv
//
// Stimulus driver and response checker for the two-output DAG logic microbenchmark.
// An 8-bit Fibonacci LFSR produces one operand vector per RUN cycle. The vector is driven
// onto a_out/b_out/c_out/d_out. The expected DUT responses are rebuilt from a short vector
// history and compared with the returned dut_out0/dut_out1 at the end of every RUN cycle
// from the third vector onward.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   begin a run (honoured in IDLE and DONE only)
//   a_out      out  [BITS]  operand a to DUT
//   b_out      out  [BITS]  operand b to DUT
//   c_out      out          operand c to DUT
//   d_out      out          operand d to DUT
//   dut_out0   in   [BITS]  DUT out0
//   dut_out1   in           DUT out1
//   busy       out          high while RUN
//   done       out          high while DONE
//   pass       out          high in DONE when no mismatch was seen
//   err_count  out  [8]     saturating mismatch count
//   fail_vec   out  [8]     index of first mismatching vector, 8'hFF if none
// ---------------------------------------------------------------------------------------------
module bm_dag1_log_drv #(
    parameter int unsigned BITS        = 2,
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [BITS-1:0] a_out,
    output logic [BITS-1:0] b_out,
    output logic            c_out,
    output logic            d_out,
    input  logic [BITS-1:0] dut_out0,
    input  logic            dut_out1,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [7:0]      fail_vec
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
    localparam logic [7:0] NO_FAIL  = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_lfsr;
    logic [7:0]      w_lfsr_next;
    logic [7:0]      r_vec_count;
    logic [7:0]      r_err_count;
    logic [7:0]      r_fail_vec;

    // Vector history: a/b one vector back, c/d one and two vectors back.
    logic [BITS-1:0] r_a1;
    logic [BITS-1:0] r_b1;
    logic            r_c1;
    logic            r_d1;
    logic            r_c2;
    logic            r_d2;

    logic [BITS-1:0] w_a;
    logic [BITS-1:0] w_b;
    logic            w_c;
    logic            w_d;
    logic            w_start_run;
    logic            w_last_vec;
    logic            w_check_en;
    logic [BITS-1:0] w_exp0;
    logic            w_exp1;
    logic            w_mismatch;

    // Current vector fields straight from the LFSR state.
    assign w_a = r_lfsr[BITS-1:0];
    assign w_b = r_lfsr[2*BITS-1:BITS];
    assign w_c = r_lfsr[6];
    assign w_d = r_lfsr[7];

    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    assign w_start_run = start && (r_state != StRun);
    assign w_last_vec  = (r_vec_count == LAST_VEC);

    // The first two vectors lack a full history, so they are never checked.
    assign w_check_en = (r_state == StRun) && (r_vec_count >= 8'd2);

    // exp0 reduces to zero, but it is built from the history so a stuck history shows up.
    assign w_exp0 = (r_a1 & r_b1) & (r_a1 ^ (r_a1 | r_b1));
    assign w_exp1 = (~w_c & w_d) | r_d1 | (r_c2 ^ r_d2);

    // Both outputs wrong in one cycle still counts as a single mismatch.
    assign w_mismatch = w_check_en && ((dut_out0 != w_exp0) || (dut_out1 != w_exp1));

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_last_vec) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    w_state_next = StRun;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        a_out = '0;
        b_out = '0;
        c_out = 1'b0;
        d_out = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        pass  = 1'b0;
        unique case (r_state)
            StIdle: begin
            end
            StRun: begin
                a_out = w_a;
                b_out = w_b;
                c_out = w_c;
                d_out = w_d;
                busy  = 1'b1;
            end
            StDone: begin
                done = 1'b1;
                pass = (r_err_count == 8'd0);
            end
            default: begin
            end
        endcase
    end

    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;

    // -----------------------------------------------------------------------------------------
    // Datapath: LFSR, vector counter, history and checker
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || w_start_run) begin
            r_lfsr      <= SEED_EFF;
            r_vec_count <= 8'd0;
            r_err_count <= 8'd0;
            r_fail_vec  <= NO_FAIL;
            r_a1        <= '0;
            r_b1        <= '0;
            r_c1        <= 1'b0;
            r_d1        <= 1'b0;
            r_c2        <= 1'b0;
            r_d2        <= 1'b0;
        end else if (r_state == StRun) begin
            r_lfsr      <= w_lfsr_next;
            r_vec_count <= r_vec_count + 8'd1;
            r_a1        <= w_a;
            r_b1        <= w_b;
            r_c1        <= w_c;
            r_d1        <= w_d;
            r_c2        <= r_c1;
            r_d2        <= r_d1;
            if (w_mismatch) begin
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
                if (r_fail_vec == NO_FAIL) begin
                    r_fail_vec <= r_vec_count;
                end
            end
        end
    end

endmodule
